// File: rtl/julia_dispatch_pkg.sv
// Shared types and default frame geometry for the Julia pixel dispatcher.
package julia_dispatch_pkg;

  // Dispatcher FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Default 640x480 frame geometry.
  localparam int FRAME_X_MAX = 639;
  localparam int FRAME_Y_MAX = 479;
  localparam int COORD_W     = 10;

endpackage

// File: rtl/julia_dispatch_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap
// and returns the first requesting channel as one-hot and encoded index.
// The pointer itself is stored by the parent.
module rr_arbiter #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   k;

  // Scan N candidates starting just after ptr; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[IW'(k)]) begin
        found         = 1'b1;
        gnt[IW'(k)]   = 1'b1;
        idx           = IW'(k);
      end
    end
  end

endmodule

// File: rtl/julia_dispatch_rr.sv
// Julia renderer pixel dispatcher: walks the frame in raster order and hands
// one (x,y) per cycle to a ready worker chosen round-robin.
// Optional stall counter enabled by defining JULIA_DISPATCH_PERF_EN.
//
// Handshake: a worker raises jw_dp_ready[i] when it can take a pixel. A grant
// is a one-cycle pulse on dp_jw_start[i] with dp_x/dp_y valid in that same
// cycle. The worker must drop ready no later than the cycle after it sees its
// start and keep it low until the pixel is finished; the dispatcher masks the
// worker granted in the current cycle so that one-cycle lag never double-grants.
module julia_dispatch_rr
  import julia_dispatch_pkg::*;
#(
  parameter int NUM_WORKERS = 16,
  parameter int X_W         = COORD_W,
  parameter int Y_W         = COORD_W,
  parameter int X_MAX       = FRAME_X_MAX,
  parameter int Y_MAX       = FRAME_Y_MAX
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_WORKERS-1:0] jw_dp_ready,
  output logic [NUM_WORKERS-1:0] dp_jw_start,
  output logic [X_W-1:0]         dp_x,
  output logic [Y_W-1:0]         dp_y,
  output logic                   busy,
  output logic                   frame_done,
  output logic [31:0]            stall_cnt,
  output state_e                 dbg_state
);

  localparam int PW = $clog2(NUM_WORKERS);

  state_e                 state_q, state_d;
  logic [X_W-1:0]         cnt_x_q, cnt_x_d;
  logic [Y_W-1:0]         cnt_y_q, cnt_y_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_WORKERS-1:0] start_q, start_d;
  logic [X_W-1:0]         dp_x_q, dp_x_d;
  logic [Y_W-1:0]         dp_y_q, dp_y_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [NUM_WORKERS-1:0] eligible;
  logic [NUM_WORKERS-1:0] gnt;
  logic [PW-1:0]          gnt_idx;
  logic                   grant_ok;
  logic                   last_px;
  logic                   accept;

  // Worker granted this cycle still shows ready; exclude it.
  assign eligible = jw_dp_ready & ~start_q;
  assign last_px  = (cnt_x_q == X_W'(X_MAX)) && (cnt_y_q == Y_W'(Y_MAX));
  assign grant_ok = (state_q == ST_RUN) && !abort && (eligible != '0);
  assign accept   = (state_q == ST_IDLE) && start && !abort;

  rr_arbiter #(.N(NUM_WORKERS), .IW(PW)) u_arb (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (grant_ok && last_px) state_d = ST_DRAIN;
      ST_DRAIN: if ((&jw_dp_ready) && (start_q == '0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Output/datapath next values: grant, coordinates, pointer and pixel counter.
  always_comb begin
    start_d = '0;
    dp_x_d  = dp_x_q;
    dp_y_d  = dp_y_q;
    ptr_d   = ptr_q;
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    if (accept) begin
      cnt_x_d = '0;
      cnt_y_d = '0;
    end else if (grant_ok) begin
      start_d = gnt;
      dp_x_d  = cnt_x_q;
      dp_y_d  = cnt_y_q;
      ptr_d   = gnt_idx;
      // Counter parks on the last pixel; it is cleared on the next start.
      if (!last_px) begin
        if (cnt_x_q == X_W'(X_MAX)) begin
          cnt_x_d = '0;
          cnt_y_d = cnt_y_q + Y_W'(1);
        end else begin
          cnt_x_d = cnt_x_q + X_W'(1);
        end
      end
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_q <= '0;
      dp_x_q  <= '0;
      dp_y_q  <= '0;
      ptr_q   <= PW'(NUM_WORKERS - 1);
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      dp_x_q  <= dp_x_d;
      dp_y_q  <= dp_y_d;
      ptr_q   <= ptr_d;
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef JULIA_DISPATCH_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of RUN cycles with nobody eligible; cleared on start.
  always_comb begin
    stall_d = stall_q;
    if (accept)
      stall_d = '0;
    else if ((state_q == ST_RUN) && (eligible == '0) && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign dp_jw_start = start_q;
  assign dp_x        = dp_x_q;
  assign dp_y        = dp_y_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_julia_dispatch_rr.sv
// Directed bench for julia_dispatch_rr: a small 4-worker 4x2 frame instance
// and a 16-worker 40x10 frame instance.
module tb_julia_dispatch_rr;
  import julia_dispatch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1: 4 workers, 4x2 frame ----------------
  logic        start = 1'b0, abort = 1'b0;
  logic [3:0]  ready = 4'b1111;
  logic [3:0]  dp_jw_start;
  logic [3:0]  dp_x, dp_y;
  logic        busy, frame_done;
  logic [31:0] stall_cnt;
  state_e      dbg_state;

  julia_dispatch_rr #(.NUM_WORKERS(4), .X_W(4), .Y_W(4), .X_MAX(3), .Y_MAX(1)) u_dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .jw_dp_ready(ready),
    .dp_jw_start(dp_jw_start), .dp_x(dp_x), .dp_y(dp_y), .busy(busy),
    .frame_done(frame_done), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- DUT 2: 16 workers, 40x10 frame ----------------
  logic        start2 = 1'b0, abort2 = 1'b0;
  logic [15:0] ready2 = '1;
  logic [15:0] dp_jw_start2;
  logic [9:0]  dp_x2, dp_y2;
  logic        busy2, frame_done2;
  logic [31:0] stall_cnt2;
  state_e      dbg_state2;

  julia_dispatch_rr #(.NUM_WORKERS(16), .X_W(10), .Y_W(10), .X_MAX(39), .Y_MAX(9)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .start(start2), .abort(abort2), .jw_dp_ready(ready2),
    .dp_jw_start(dp_jw_start2), .dp_x(dp_x2), .dp_y(dp_y2), .busy(busy2),
    .frame_done(frame_done2), .stall_cnt(stall_cnt2), .dbg_state(dbg_state2)
  );

`ifdef JULIA_DISPATCH_PERF_EN
  localparam int EXP_STALL = 5;
`else
  localparam int EXP_STALL = 0;
`endif

  // ---------------- worker model and grant log ----------------
  logic [3:0]  en = 4'b1111;
  int          lat = 1;
  logic [3:0]  pend = '0;
  int          wcnt[4];
  logic [15:0] prev2 = '0;

  logic [3:0]  g_start[$];
  logic [3:0]  g_x[$];
  logic [3:0]  g_y[$];
  int          g_cyc[$];
  state_e      g_state[$];
  int          fd_cnt = 0, fd2_cnt = 0, cyc = 0;
  int          n_tests = 0, n_fail = 0;

  // One clock: sample outputs 1 time unit after the edge, log grants, then
  // update the worker models (ready drops the cycle after start, stays low
  // for lat cycles, then follows en).
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (dp_jw_start != '0) begin
      g_start.push_back(dp_jw_start);
      g_x.push_back(dp_x);
      g_y.push_back(dp_y);
      g_cyc.push_back(cyc);
      g_state.push_back(dbg_state);
    end
    if (frame_done)  fd_cnt++;
    if (frame_done2) fd2_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        ready[i] = 1'b0; wcnt[i] = lat; pend[i] = 1'b0;
      end else if (wcnt[i] > 0) begin
        wcnt[i]--;
        if (wcnt[i] == 0) ready[i] = en[i];
      end else begin
        ready[i] = en[i];
      end
      if (dp_jw_start[i]) pend[i] = 1'b1;
    end
    ready2 = ~prev2;
    prev2  = dp_jw_start2;
  endtask

  task automatic clear_log();
    g_start.delete(); g_x.delete(); g_y.delete(); g_cyc.delete(); g_state.delete();
    fd_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int b;
    b = budget;
    while (fd_cnt == 0 && b > 0) begin
      cycle();
      b--;
    end
    repeat (2) cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_tests++; if (dp_jw_start !== 4'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0000", dp_jw_start); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
    n_tests++; if (dp_x !== 4'd0 || dp_y !== 4'd0) begin n_fail++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", dp_x, dp_y); end
    n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    n_tests++; if (busy2 !== 1'b0 || dp_jw_start2 !== 16'd0) begin n_fail++; $display("FAIL reset_dut2: busy %b start %h want 0", busy2, dp_jw_start2); end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) cycle();
    n_tests++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: state %0d busy %b want IDLE/0", dbg_state, busy); end
  endtask

  task automatic test_full_frame();
    int c0;
    clear_log();
    pulse_start();
    c0 = cyc;
    n_tests++; if (busy !== 1'b1 || dbg_state !== ST_RUN) begin n_fail++; $display("FAIL full_run: busy %b state %0d want 1/RUN", busy, dbg_state); end
    run_until_done(40);
    n_tests++;
    if (g_start.size() != 8) begin
      n_fail++; $display("FAIL full_count: got %0d grants want 8", g_start.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++; if (g_start[k] !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL full_gnt%0d: got %b want %b", k, g_start[k], 4'(1 << (k % 4))); end
        n_tests++; if (g_x[k] !== 4'(k % 4) || g_y[k] !== 4'(k / 4)) begin n_fail++; $display("FAIL full_xy%0d: got (%0d,%0d) want (%0d,%0d)", k, g_x[k], g_y[k], k % 4, k / 4); end
        n_tests++; if (g_cyc[k] != c0 + 1 + k) begin n_fail++; $display("FAIL full_cyc%0d: got %0d want %0d", k, g_cyc[k], c0 + 1 + k); end
      end
      n_tests++; if (g_state[6] !== ST_RUN || g_state[7] !== ST_DRAIN) begin n_fail++; $display("FAIL full_drain: got %0d/%0d want RUN/DRAIN", g_state[6], g_state[7]); end
    end
    n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL full_done: got %0d pulses want 1", fd_cnt); end
    n_tests++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL full_idle: busy %b state %0d want 0/IDLE", busy, dbg_state); end
  endtask

  task automatic test_single_worker();
    int c0, b;
    lat = 3; en = 4'b0100; ready = 4'b0100;
    clear_log();
    pulse_start();
    c0 = cyc;
    b = 60;
    while (g_start.size() < 8 && b > 0) begin cycle(); b--; end
    n_tests++;
    if (g_start.size() != 8) begin
      n_fail++; $display("FAIL single_count: got %0d grants want 8", g_start.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++; if (g_start[k] !== 4'b0100) begin n_fail++; $display("FAIL single_gnt%0d: got %b want 0100", k, g_start[k]); end
        n_tests++; if (g_x[k] !== 4'(k % 4) || g_y[k] !== 4'(k / 4)) begin n_fail++; $display("FAIL single_xy%0d: got (%0d,%0d) want (%0d,%0d)", k, g_x[k], g_y[k], k % 4, k / 4); end
        n_tests++; if (g_cyc[k] != c0 + 1 + 5 * k) begin n_fail++; $display("FAIL single_cyc%0d: got %0d want %0d", k, g_cyc[k], c0 + 1 + 5 * k); end
      end
    end
    repeat (6) cycle();
    n_tests++; if (dbg_state !== ST_DRAIN || fd_cnt != 0) begin n_fail++; $display("FAIL single_drain: state %0d done %0d want DRAIN/0", dbg_state, fd_cnt); end
    en = 4'b1111;
    run_until_done(20);
    n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL single_done: got %0d pulses want 1", fd_cnt); end
    lat = 1;
  endtask

  task automatic test_stall();
    en = 4'b0000; ready = 4'b0000;
    clear_log();
    pulse_start();
    repeat (5) cycle();
    n_tests++; if (g_start.size() != 0) begin n_fail++; $display("FAIL stall_nogrant: got %0d grants want 0", g_start.size()); end
    n_tests++; if (stall_cnt !== 32'(EXP_STALL)) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, EXP_STALL); end
    n_tests++; if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL stall_state: got %0d want RUN", dbg_state); end
    en = 4'b1111; ready = 4'b1111;
    run_until_done(40);
    n_tests++;
    if (g_start.size() != 8) begin
      n_fail++; $display("FAIL stall_count: got %0d grants want 8", g_start.size());
    end else begin
      n_tests++; if (g_start[0] !== 4'b1000 || g_x[0] !== 4'd0 || g_y[0] !== 4'd0) begin n_fail++; $display("FAIL stall_first: got %b (%0d,%0d) want 1000 (0,0)", g_start[0], g_x[0], g_y[0]); end
    end
    n_tests++; if (stall_cnt !== 32'(EXP_STALL)) begin n_fail++; $display("FAIL stall_hold: got %0d want %0d", stall_cnt, EXP_STALL); end
    n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL stall_done: got %0d pulses want 1", fd_cnt); end
  endtask

  task automatic test_abort();
    int b;
    clear_log();
    pulse_start();
    b = 10;
    while (g_start.size() < 3 && b > 0) begin cycle(); b--; end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    n_tests++; if (dp_jw_start !== 4'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_stop: start %b busy %b state %0d want 0000/0/IDLE", dp_jw_start, busy, dbg_state); end
    repeat (8) cycle();
    n_tests++; if (g_start.size() != 3 || fd_cnt != 0) begin n_fail++; $display("FAIL abort_quiet: grants %0d done %0d want 3/0", g_start.size(), fd_cnt); end
    n_tests++;
    if (g_start.size() >= 3 && (g_start[2] !== 4'b0010 || g_x[2] !== 4'd2)) begin n_fail++; $display("FAIL abort_third: got %b x=%0d want 0010 x=2", g_start[2], g_x[2]); end
    abort = 1'b1; cycle(); abort = 1'b0;
    n_tests++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: state %0d busy %b want IDLE/0", dbg_state, busy); end
    start = 1'b1; abort = 1'b1; cycle(); start = 1'b0; abort = 1'b0;
    n_tests++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL abort_wins: state %0d busy %b want IDLE/0", dbg_state, busy); end
    clear_log();
    pulse_start();
    run_until_done(40);
    n_tests++;
    if (g_start.size() != 8) begin
      n_fail++; $display("FAIL abort_restart_count: got %0d grants want 8", g_start.size());
    end else begin
      n_tests++; if (g_start[0] !== 4'b0100 || g_x[0] !== 4'd0 || g_y[0] !== 4'd0) begin n_fail++; $display("FAIL abort_restart: got %b (%0d,%0d) want 0100 (0,0)", g_start[0], g_x[0], g_y[0]); end
    end
    n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL abort_restart_done: got %0d pulses want 1", fd_cnt); end
  endtask

  task automatic test_start_in_run();
    clear_log();
    pulse_start();
    repeat (2) cycle();
    pulse_start();
    run_until_done(40);
    repeat (4) cycle();
    n_tests++;
    if (g_start.size() != 8) begin
      n_fail++; $display("FAIL rerun_count: got %0d grants want 8", g_start.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++; if (g_x[k] !== 4'(k % 4) || g_y[k] !== 4'(k / 4)) begin n_fail++; $display("FAIL rerun_xy%0d: got (%0d,%0d) want (%0d,%0d)", k, g_x[k], g_y[k], k % 4, k / 4); end
      end
    end
    n_tests++; if (fd_cnt != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL rerun_done: pulses %0d busy %b want 1/0", fd_cnt, busy); end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    pulse_start();
    repeat (3) cycle();
    n_rst = 1'b0;
    #2;
    n_tests++; if (dp_jw_start !== 4'b0 || busy !== 1'b0 || dp_x !== 4'd0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_async: start %b busy %b x %0d state %0d want 0", dp_jw_start, busy, dp_x, dbg_state); end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) cycle();
    clear_log();
    pulse_start();
    run_until_done(40);
    n_tests++;
    if (g_start.size() != 8) begin
      n_fail++; $display("FAIL midrst_count: got %0d grants want 8", g_start.size());
    end else begin
      n_tests++; if (g_start[0] !== 4'b0001 || g_x[0] !== 4'd0 || g_y[0] !== 4'd0) begin n_fail++; $display("FAIL midrst_first: got %b (%0d,%0d) want 0001 (0,0)", g_start[0], g_x[0], g_y[0]); end
    end
  endtask

  task automatic test_default_frame();
    int k, b, lx, ly;
    k = 0; b = 700; lx = -1; ly = -1;
    fd2_cnt = 0;
    start2 = 1'b1; cycle(); start2 = 1'b0;
    while (fd2_cnt == 0 && b > 0) begin
      cycle();
      b--;
      if (dp_jw_start2 != '0) begin
        n_tests++; if (dp_jw_start2 !== 16'(1 << (k % 16))) begin n_fail++; $display("FAIL big_gnt%0d: got %h want %h", k, dp_jw_start2, 16'(1 << (k % 16))); end
        n_tests++; if (dp_x2 !== 10'(k % 40) || dp_y2 !== 10'(k / 40)) begin n_fail++; $display("FAIL big_xy%0d: got (%0d,%0d) want (%0d,%0d)", k, dp_x2, dp_y2, k % 40, k / 40); end
        lx = int'(dp_x2); ly = int'(dp_y2);
        k++;
      end
    end
    repeat (3) cycle();
    n_tests++; if (k != 400) begin n_fail++; $display("FAIL big_count: got %0d grants want 400", k); end
    n_tests++; if (lx != 39 || ly != 9) begin n_fail++; $display("FAIL big_last: got (%0d,%0d) want (39,9)", lx, ly); end
    n_tests++; if (fd2_cnt != 1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL big_done: pulses %0d busy %b want 1/0", fd2_cnt, busy2); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    test_reset();
    test_full_frame();
    test_single_worker();
    test_stall();
    test_abort();
    test_start_in_run();
    test_reset_mid_frame();
    test_default_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
